// File: rtl/dmem_if.sv
// Request/response bundle between the load/store unit and dmem_ctrl.
//   master : load/store unit side; drives the request fields and
//            observes ready, the response and busy.
//   slave  : memory controller side.
// Signals:
//   req_valid/req_ready          request handshake
//   req_load/req_store           access kind
//   req_funct3                   access size in [1:0] (B/H/W/D)
//   req_addr, req_wdata, req_we  byte address, lane-positioned data, byte mask
//   rsp_valid                    one-cycle response strobe
//   rsp_rdata                    full aligned word (0 for stores and faults)
//   rsp_fault, rsp_fault_code    fault flag and reason (01/10/11)
//   busy                         controller occupied (stall the core)
interface dmem_if #(
  parameter int WIDTH = 64
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_load;
  logic                 req_store;
  logic [2:0]           req_funct3;
  logic [WIDTH-1:0]     req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic [WIDTH/8-1:0]   req_we;
  logic                 rsp_valid;
  logic [WIDTH-1:0]     rsp_rdata;
  logic                 rsp_fault;
  logic [1:0]           rsp_fault_code;
  logic                 busy;

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_we,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code, busy
  );

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_we,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the load/store unit.
// Accepts one load or store at a time, waits LATENCY cycles, commits the
// access to a DEPTH x WIDTH byte-writable array and returns a one-cycle
// response carrying the full aligned word. Misaligned, out-of-range and
// load+store requests are reported as faults and never touch the array.
// Ports:
//   clk    : clock, all state changes on its rising edge
//   rst_n  : synchronous active-low reset
//   bus    : dmem_if slave modport (request, response, busy)
module dmem_ctrl #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  // Latched request; fault reason is resolved at acceptance (00 = no fault).
  logic [AW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]     we_q, we_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic [1:0]        code_q, code_d;

  // Response registers; they hold between responses.
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [1:0]        rcode_q, rcode_d;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              do_write;
  logic              unused_funct3;

  // Size encoding ignores funct3[2] (signedness is handled downstream).
  assign unused_funct3 = bus.req_funct3[2];

  function automatic logic [1:0] fault_code(input logic             ld,
                                            input logic             st,
                                            input logic [1:0]       sz,
                                            input logic [WIDTH-1:0] addr);
    logic misal;
    case (sz)
      2'd0:    misal = 1'b0;
      2'd1:    misal = addr[0];
      2'd2:    misal = |addr[1:0];
      default: misal = |addr[2:0];
    endcase
    if (ld && st)                  return 2'b11;
    else if (|addr[WIDTH-1:3+AW])  return 2'b10;
    else if (misal)                return 2'b01;
    else                           return 2'b00;
  endfunction

  assign accept   = (state_q == S_IDLE) && rst_n && bus.req_valid &&
                    (bus.req_load || bus.req_store);
  assign commit   = (state_q == S_WAIT) && (cnt_q == 3'd0);
  // Reset on the commit edge itself suppresses the write.
  assign do_write = commit && rst_n && store_q && (code_q == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    load_d  = load_q;
    store_d = store_q;
    code_d  = code_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    rcode_d = rcode_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = 3'(LATENCY - 1);
          idx_d   = bus.req_addr[3+AW-1:3];
          wdata_d = bus.req_wdata;
          we_d    = bus.req_we;
          load_d  = bus.req_load;
          store_d = bus.req_store;
          code_d  = fault_code(bus.req_load, bus.req_store,
                               bus.req_funct3[1:0], bus.req_addr);
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          rdata_d = (load_q && (code_q == 2'b00)) ? mem[idx_q] : '0;
          fault_d = (code_q != 2'b00);
          rcode_d = code_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      rcode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      rcode_q <= rcode_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    we_q    <= we_d;
    load_q  <= load_d;
    store_q <= store_d;
    code_q  <= code_d;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (we_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.req_ready      = rst_n && (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.rsp_valid      = (state_q == S_RESP);
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_fault      = fault_q;
  assign bus.rsp_fault_code = rcode_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  localparam int DEPTH = 512;
  localparam int NW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if #(.WIDTH(64)) if1 ();
  dmem_if #(.WIDTH(64)) if4 ();

  dmem_ctrl #(.WIDTH(64), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_ctrl #(.WIDTH(64), .DEPTH(DEPTH), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct packed {
    logic [63:0] rdata;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t q1[$];
  exp_t q4[$];
  logic [63:0] mdl [2][NW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Response monitors: pop expected responses whenever a DUT strobes.
  always @(negedge clk) begin
    exp_t e;
    if (if1.rsp_valid === 1'b1) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1_rdata", if1.rsp_rdata, e.rdata);
        chk("rsp1_fault", 64'(if1.rsp_fault), 64'(e.fault));
        chk("rsp1_code", 64'(if1.rsp_fault_code), 64'(e.code));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if4.rsp_valid === 1'b1) begin
      if (q4.size() == 0) chk("rsp4_unexpected", 64'd1, 64'd0);
      else begin
        e = q4.pop_front();
        chk("rsp4_rdata", if4.rsp_rdata, e.rdata);
        chk("rsp4_fault", 64'(if4.rsp_fault), 64'(e.fault));
        chk("rsp4_code", 64'(if4.rsp_fault_code), 64'(e.code));
      end
    end
  end

  function automatic logic rdy(input int s);
    return (s == 0) ? if1.req_ready : if4.req_ready;
  endfunction
  function automatic logic bsy(input int s);
    return (s == 0) ? if1.busy : if4.busy;
  endfunction
  function automatic logic rv(input int s);
    return (s == 0) ? if1.rsp_valid : if4.rsp_valid;
  endfunction
  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 4;
  endfunction

  task automatic drive(input int s, input logic v, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [7:0] we);
    if (s == 0) begin
      if1.req_valid = v; if1.req_load = ld; if1.req_store = st;
      if1.req_funct3 = f3; if1.req_addr = a; if1.req_wdata = wd; if1.req_we = we;
    end else begin
      if4.req_valid = v; if4.req_load = ld; if4.req_store = st;
      if4.req_funct3 = f3; if4.req_addr = a; if4.req_wdata = wd; if4.req_we = we;
    end
  endtask

  // Reference model: one request at a time, memory as an array of words.
  task automatic apply_model(input int s, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd, input logic [7:0] we);
    exp_t e;
    int code;
    int w;
    longint unsigned sz;
    sz = 64'd1 << f3[1:0];
    if (ld && st)                      code = 3;
    else if ((a >> 3) >= 64'(DEPTH))   code = 2;
    else if ((a % sz) != 0)            code = 1;
    else                               code = 0;
    e.fault = (code != 0);
    e.code  = 2'(code);
    e.rdata = '0;
    if (code == 0) begin
      w = int'(a >> 3);
      if (ld) e.rdata = mdl[s][w];
      else begin
        for (int b = 0; b < 8; b++)
          if (we[b]) mdl[s][w][8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (s == 0) q1.push_back(e); else q4.push_back(e);
  endtask

  task automatic do_req(input int s, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [7:0] we);
    int L;
    int busy_n;
    int rsp_k;
    bit acc;
    L = lat_of(s);
    @(negedge clk);
    drive(s, 1'b1, ld, st, f3, a, wd, we);
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (rdy(s)) acc = 1;
      else @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 64'd0, 64'd1);
      drive(s, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
      return;
    end
    @(posedge clk);
    apply_model(s, ld, st, f3, a, wd, we);
    #1 drive(s, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
    busy_n = 0;
    rsp_k  = 0;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (bsy(s)) busy_n++;
      if (rv(s) && rsp_k == 0) rsp_k = k;
    end
    chk("rsp_latency", 64'(rsp_k), 64'(L + 1));
    chk("busy_cycles", 64'(busy_n), 64'(L + 1));
    chk("ready_after", 64'(rdy(s)), 64'd1);
  endtask

  task automatic drop_req(input int s);
    @(negedge clk);
    drive(s, 1'b1, 1'b0, 1'b0, 3'd3, 64'h8, 64'd0, 8'hFF);
    repeat (3) begin
      @(negedge clk);
      chk("drop_busy", 64'(bsy(s)), 64'd0);
    end
    drive(s, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int busy_gap;
    logic [63:0] a;
    logic [63:0] wd;
    logic ld, st;
    int r;

    drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 64'(rdy(s)), 64'd0);
      chk("rst_busy", 64'(bsy(s)), 64'd0);
      chk("rst_rsp_valid", 64'(rv(s)), 64'd0);
    end
    chk("rst_rdata1", if1.rsp_rdata, 64'd0);
    chk("rst_fault1", 64'(if1.rsp_fault), 64'd0);
    chk("rst_code1", 64'(if1.rsp_fault_code), 64'd0);
    chk("rst_rdata4", if4.rsp_rdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rel_ready", 64'(rdy(s)), 64'd1);
      chk("rel_busy", 64'(bsy(s)), 64'd0);
    end

    // Give the modelled words known contents.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < NW; w++)
        do_req(s, 1'b0, 1'b1, 3'd3, 64'(w * 8), {$urandom, $urandom}, 8'hFF);

    // Directed traffic on LATENCY=1
    do_req(0, 1'b0, 1'b1, 3'd3, 64'h10, 64'h1122334455667788, 8'hFF);
    do_req(0, 1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 8'd0);
    do_req(0, 1'b0, 1'b1, 3'd0, 64'h15, 64'h0000AA0000000000, 8'h20);
    do_req(0, 1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 8'd0);
    do_req(0, 1'b1, 1'b0, 3'd2, 64'h12, 64'd0, 8'd0);
    do_req(0, 1'b1, 1'b0, 3'd3, 64'(DEPTH * 8), 64'd0, 8'd0);
    do_req(0, 1'b1, 1'b1, 3'd3, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    do_req(0, 1'b0, 1'b1, 3'd3, 64'h11, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    do_req(0, 1'b0, 1'b1, 3'd3, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    do_req(0, 1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 8'd0);
    drop_req(0);

    // LATENCY=4 with req_valid held high: one acceptance every 6 cycles.
    wd = 64'hA5A55A5A0F0FF0F0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b1, 3'd3, 64'h30, wd, 8'hFF);
    last = -1;
    busy_gap = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (bsy(1)) busy_gap++;
      if (rdy(1)) begin
        apply_model(1, 1'b0, 1'b1, 3'd3, 64'h30, wd, 8'hFF);
        if (last >= 0) begin
          chk("hold_gap", 64'(c - last), 64'd6);
          chk("hold_busy", 64'(busy_gap), 64'd5);
        end
        last = c;
        busy_gap = 0;
      end
    end
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
    repeat (8) @(negedge clk);
    do_req(1, 1'b1, 1'b0, 3'd3, 64'h30, 64'd0, 8'd0);

    // Store aborted by reset during WAIT must not write or respond.
    @(negedge clk);
    chk("abort_ready", 64'(rdy(1)), 64'd1);
    drive(1, 1'b1, 1'b0, 1'b1, 3'd3, 64'h20, 64'hDEADBEEFCAFEF00D, 8'hFF);
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0);
    @(negedge clk);
    chk("abort_busy_wait", 64'(bsy(1)), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_ready", 64'(rdy(1)), 64'd0);
    chk("abort_rst_busy", 64'(bsy(1)), 64'd0);
    chk("abort_rst_rdata", if4.rsp_rdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_ready", 64'(rdy(1)), 64'd1);
    repeat (6) @(negedge clk);
    do_req(1, 1'b1, 1'b0, 3'd3, 64'h20, 64'd0, 8'd0);

    // Randomized traffic on both controllers.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 99);
        ld = (r < 45) || (r >= 90 && r < 95);
        st = (r >= 45 && r < 95);
        r = $urandom_range(0, 9);
        if (r < 8)       a = 64'($urandom_range(0, NW * 8 - 1));
        else if (r == 8) a = 64'(DEPTH * 8) + 64'($urandom_range(0, 4095));
        else             a = {1'b1, 31'($urandom), $urandom};
        if (!ld && !st) drop_req(s);
        else do_req(s, ld, st, 3'($urandom_range(0, 7)), a,
                    {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      end
    end

    repeat (4) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
